eg2000_tape_ram_arbiter: RTL and testbench

- Single-port arbiter/sequencer for the 128 KB tape RAM in the CAS player.
- Three requesters share the RAM: CAS download writer (WR), eject eraser (ER, writes 0x00) and playback reader (RD).
- Replaces ad-hoc address/write-enable muxing with a req/gnt handshake and fixed priority WR > ER > RD.
- Returns registered read data with a valid strobe.

---
 rtl/eg2000_tape_ram_arbiter.sv | 141 ++++++++++++++
 tb/tb_eg2000_tape_ram_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/eg2000_tape_ram_arbiter.sv
// rtl/eg2000_tape_ram_arbiter.sv - fixed-priority (WR > ER > RD) arbiter for the 128 KB tape RAM
// Optional RD starvation guard: define EG2000_ARB_STARVE_EN.
module eg2000_tape_ram_arbiter #(
  parameter int AW           = 17,
  parameter int STARVE_LIMIT = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  output logic          wr_gnt,
  input  logic          er_req,
  input  logic [AW-1:0] er_addr,
  output logic          er_gnt,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_gnt,
  output logic [7:0]    rd_data,
  output logic          rd_valid,
  output logic [AW-1:0] ram_a,
  output logic [7:0]    ram_d,
  output logic          ram_we_n,
  input  logic [7:0]    ram_q,
  output logic [1:0]    owner,
  output logic          busy
);

  // State encoding doubles as the owner code (0 none, 1 WR, 2 ER, 3 RD).
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_WR   = 2'd1,
    ARB_ER   = 2'd2,
    ARB_RD   = 2'd3
  } arb_state_t;

  arb_state_t    state_q, state_d;
  logic [AW-1:0] ram_a_q, ram_a_d;
  logic [7:0]    ram_d_q, ram_d_d;
  logic          rd_pend_q;
  logic          rd_valid_q;
  logic [7:0]    rd_data_q;

  logic wr_elig, er_elig, rd_elig;
  logic starve_force;

  // The requester granted this cycle still shows req (it drops on the next edge), so mask it.
  assign wr_elig = wr_req && (state_q != ARB_WR);
  assign er_elig = er_req && (state_q != ARB_ER);
  assign rd_elig = rd_req && (state_q != ARB_RD);

`ifdef EG2000_ARB_STARVE_EN
  logic [6:0] starve_q, starve_d;

  assign starve_force = (starve_q >= 7'(STARVE_LIMIT));

  // Count cycles RD is eligible but loses; clears when RD is granted.
  always_comb begin
    starve_d = starve_q;
    if (state_q == ARB_RD || state_d == ARB_RD) begin
      starve_d = 7'd0;
    end else if (rd_elig && !starve_force) begin
      starve_d = starve_q + 7'd1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= 7'd0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  // Without the guard the limit has no effect; pure fixed priority.
  assign starve_force = (STARVE_LIMIT < 0);
`endif

  // Next grant selection and the RAM address/data that go with it.
  always_comb begin
    state_d = ARB_IDLE;
    ram_a_d = ram_a_q;
    ram_d_d = ram_d_q;
    if (starve_force && rd_elig) begin
      state_d = ARB_RD;
      ram_a_d = rd_addr;
    end else if (wr_elig) begin
      state_d = ARB_WR;
      ram_a_d = wr_addr;
      ram_d_d = wr_data;
    end else if (er_elig) begin
      state_d = ARB_ER;
      ram_a_d = er_addr;
      ram_d_d = 8'h00;
    end else if (rd_elig) begin
      state_d = ARB_RD;
      ram_a_d = rd_addr;
    end
  end

  // Grant state and RAM address/data registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      ram_a_q <= '0;
      ram_d_q <= 8'h00;
    end else begin
      state_q <= state_d;
      ram_a_q <= ram_a_d;
      ram_d_q <= ram_d_d;
    end
  end

  // Read return pipeline: RAM q is valid the cycle after rd_gnt, captured at its end.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'h00;
    end else begin
      rd_pend_q  <= (state_q == ARB_RD);
      rd_valid_q <= rd_pend_q;
      if (rd_pend_q) begin
        rd_data_q <= ram_q;
      end
    end
  end

  assign wr_gnt   = (state_q == ARB_WR);
  assign er_gnt   = (state_q == ARB_ER);
  assign rd_gnt   = (state_q == ARB_RD);
  assign ram_we_n = !((state_q == ARB_WR) || (state_q == ARB_ER));
  assign ram_a    = ram_a_q;
  assign ram_d    = ram_d_q;
  assign owner    = state_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign busy     = wr_req || er_req || rd_req || (state_q != ARB_IDLE) || rd_pend_q;

endmodule

// File: tb/tb_eg2000_tape_ram_arbiter.sv
// tb/tb_eg2000_tape_ram_arbiter.sv - scoreboard bench for eg2000_tape_ram_arbiter
module tb_eg2000_tape_ram_arbiter;
  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_req = 1'b0, er_req = 1'b0, rd_req = 1'b0;
  logic [AW-1:0] wr_addr = '0, er_addr = '0, rd_addr = '0;
  logic [7:0]    wr_data = 8'h00;
  logic          wr_gnt, er_gnt, rd_gnt, rd_valid, ram_we_n, busy;
  logic [7:0]    rd_data, ram_d;
  logic [7:0]    ram_q = 8'h00;
  logic [AW-1:0] ram_a;
  logic [1:0]    owner;

  eg2000_tape_ram_arbiter #(.AW(AW), .STARVE_LIMIT(64)) dut (
    .clk(clk), .reset(reset),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .er_req(er_req), .er_addr(er_addr), .er_gnt(er_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .ram_a(ram_a), .ram_d(ram_d), .ram_we_n(ram_we_n), .ram_q(ram_q),
    .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM.
  logic [7:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (!ram_we_n) mem[ram_a] <= ram_d;
    ram_q <= mem[ram_a];
  end

  typedef struct {
    logic [1:0]    owner;
    logic [AW-1:0] addr;
    logic [7:0]    data;
    logic          we_n;
  } gexp_t;

  gexp_t      gq[$];
  logic [7:0] rq[$];
  int         lat_q[$];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  bit         mon_en = 1'b0;
  bit         busy_next = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void push_g(logic [1:0] o, logic [AW-1:0] a, logic [7:0] d);
    gexp_t e;
    e.owner = o; e.addr = a; e.data = d; e.we_n = (o == 2'd3);
    gq.push_back(e);
  endfunction

  // Monitor: pops grant and read-data expectations whenever the DUT presents them.
  always @(negedge clk) begin
    gexp_t    e;
    logic [3:0] oh;
    int       exp_cyc;
    cyc++;
    if (mon_en) begin
      if (busy_next) begin
        chk("busy_read_in_flight", busy, 1);
        busy_next = 1'b0;
      end
      if (wr_gnt || er_gnt || rd_gnt) begin
        if (gq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_grant: got owner %0d expected no grant (cycle %0d)", owner, cyc);
        end else begin
          e = gq.pop_front();
          oh = 4'b1000 >> e.owner;
          chk("gnt_lines", {wr_gnt, er_gnt, rd_gnt}, oh[2:0]);
          chk("owner", owner, e.owner);
          chk("ram_a", ram_a, e.addr);
          chk("ram_we_n", ram_we_n, e.we_n);
          if (!e.we_n) chk("ram_d", ram_d, e.data);
        end
        if (rd_gnt) begin
          lat_q.push_back(cyc + 2);
          busy_next = 1'b1;
        end
      end else begin
        chk("idle_owner", owner, 0);
        chk("idle_we_n", ram_we_n, 1);
      end
      if (rd_valid) begin
        if (rq.size() == 0 || lat_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rd_valid: got data 0x%0h expected no valid (cycle %0d)", rd_data, cyc);
        end else begin
          exp_cyc = lat_q.pop_front();
          chk("rd_latency", cyc, exp_cyc);
          chk("rd_data", rd_data, rq.pop_front());
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One requester transaction; 'late' keeps req up through the edge after the grant.
  task automatic access(input int who, input logic [AW-1:0] a, input logic [7:0] d, input bit late);
    logic g;
    @(posedge clk); #1;
    case (who)
      1: begin wr_addr = a; wr_data = d; wr_req = 1'b1; end
      2: begin er_addr = a; er_req = 1'b1; end
      default: begin rd_addr = a; rd_req = 1'b1; end
    endcase
    g = 1'b0;
    for (int i = 0; i < 200 && !g; i++) begin
      @(posedge clk); #1;
      g = (who == 1) ? wr_gnt : (who == 2) ? er_gnt : rd_gnt;
    end
    if (!g) begin
      checks++; errors++;
      $display("FAIL grant_timeout: requester %0d got no grant expected one within 200 cycles", who);
    end
    if (late) step(1);
    case (who)
      1: wr_req = 1'b0;
      2: er_req = 1'b0;
      default: rd_req = 1'b0;
    endcase
  endtask

  int first_rd;
  int rd_cnt;

  initial begin
    // Reset state
    step(3);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_wr_gnt", wr_gnt, 0);
    chk("rst_er_gnt", er_gnt, 0);
    chk("rst_rd_gnt", rd_gnt, 0);
    chk("rst_owner", owner, 0);
    chk("rst_we_n", ram_we_n, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 8'h00);
    chk("rst_ram_a", ram_a, 0);
    chk("rst_ram_d", ram_d, 8'h00);
    mon_en = 1'b1;

    // Write then read back
    push_g(2'd1, 17'h00010, 8'hAA);
    access(1, 17'h00010, 8'hAA, 0);
    push_g(2'd3, 17'h00010, 8'h00);
    rq.push_back(8'hAA);
    access(3, 17'h00010, 8'h00, 0);
    step(4);

    // Simultaneous requests: WR, ER, RD on consecutive cycles
    push_g(2'd1, 17'h00020, 8'h5A);
    push_g(2'd2, 17'h00030, 8'h00);
    push_g(2'd3, 17'h00010, 8'h00);
    rq.push_back(8'hAA);
    fork
      access(1, 17'h00020, 8'h5A, 1);
      access(2, 17'h00030, 8'h00, 1);
      access(3, 17'h00010, 8'h00, 1);
    join
    step(4);

    // Erase after write clears the byte
    push_g(2'd1, 17'h00040, 8'h55);
    access(1, 17'h00040, 8'h55, 0);
    push_g(2'd2, 17'h00040, 8'h00);
    access(2, 17'h00040, 8'h00, 0);
    push_g(2'd3, 17'h00040, 8'h00);
    rq.push_back(8'h00);
    access(3, 17'h00040, 8'h00, 0);
    step(4);

    // Late req drop: no second grant in the cycle after the grant
    push_g(2'd1, 17'h00050, 8'h77);
    access(1, 17'h00050, 8'h77, 1);
    @(negedge clk);
    chk("mask_no_regrant", wr_gnt, 0);
    chk("mask_owner", owner, 0);
    step(3);

    // Top-of-range address and wrap neighbour
    push_g(2'd1, 17'h1FFFF, 8'hC3);
    access(1, 17'h1FFFF, 8'hC3, 0);
    push_g(2'd1, 17'h00000, 8'h3C);
    access(1, 17'h00000, 8'h3C, 0);
    push_g(2'd3, 17'h1FFFF, 8'h00);
    rq.push_back(8'hC3);
    access(3, 17'h1FFFF, 8'h00, 0);
    push_g(2'd3, 17'h00000, 8'h00);
    rq.push_back(8'h3C);
    access(3, 17'h00000, 8'h00, 0);
    step(4);

    // Reset while a read is in flight drops rd_valid
    push_g(2'd3, 17'h00010, 8'h00);
    access(3, 17'h00010, 8'h00, 0);
    step(1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    lat_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_drops_rd_valid", rd_valid, 0);
    end
    chk("reset_rd_data", rd_data, 8'h00);
    step(1);

    // Continuous WR/ER traffic with a waiting reader
    mon_en = 1'b0;
    wr_addr = 17'h00100; wr_data = 8'h11; er_addr = 17'h00200; rd_addr = 17'h00010;
    wr_req = 1'b1; er_req = 1'b1; rd_req = 1'b1;
    first_rd = -1;
    rd_cnt = 0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (rd_gnt) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = k;
      end
    end
    #1;
    wr_req = 1'b0; er_req = 1'b0; rd_req = 1'b0;
`ifdef EG2000_ARB_STARVE_EN
    chk("starve_rd_granted", (first_rd >= 1 && first_rd <= 65), 1);
`else
    chk("starve_no_rd_gnt", rd_cnt, 0);
`endif
    step(4);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(1);

    chk("gq_drained", gq.size(), 0);
    chk("rq_drained", rq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 ns");
    $fatal(1);
  end

endmodule
